// File: rtl/frame_readout_scheduler_pkg.sv
// frame_readout_scheduler_pkg: shared state encoding and constants for the frame readout scheduler
package frame_readout_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        FETCH,
        WAIT_DATA,
        PRESENT,
        DONE
    } state_t;

    localparam logic [7:0] HDR_SYNC               = 8'hA5;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/frame_readout_scheduler_starvation.sv
// starvation_timer: loadable down-counter that pulses expire on the CYCLES-th consecutive enabled cycle
//   CLK    in  system clock
//   RESET  in  asynchronous active-high reset
//   clr    in  reload the counter with CYCLES
//   en     in  count one starved cycle
//   expire out high in the enabled cycle that uses up the budget
module starvation_timer
    import frame_readout_scheduler_pkg::*;
#(
    parameter int CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int           W    = $clog2(CYCLES + 1);
    localparam logic [W-1:0] INIT = W'(CYCLES);

    logic [W-1:0] cnt;

    assign expire = en && (cnt <= W'(1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= INIT;
        else if (clr)
            cnt <= INIT;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

endmodule

// File: rtl/frame_readout_scheduler.sv
// frame_readout_scheduler: reads one frame of FRAME_LENGTH bytes from the sample store and presents them with valid/ready
//   CLK, RESET           clock, asynchronous active-high reset
//   ENABLE               run enable; low aborts any frame in progress
//   FRAME_LENGTH         payload bytes per frame, latched at frame start
//   FIFO_READY/DATA/RD   store status, read data (1 cycle after FIFO_RD), read strobe
//   OUT_DATA/VALID/READY byte handshake towards the parallel port
//   FRAME_SYNC           high from the first presented byte until the last handshake
//   FRAME_DONE/ABORT     1-cycle completion / abort pulses
//   FRAME_CNT            completed frames, wraps at 255
// Build option: define FRAME_HEADER_EN to prefix each frame with 0xA5 and FRAME_CNT.
module frame_readout_scheduler
    import frame_readout_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int LEN_W          = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [LEN_W-1:0] FRAME_LENGTH,
    input  logic             FIFO_READY,
    input  logic [7:0]       FIFO_DATA,
    output logic             FIFO_RD,
    output logic [7:0]       OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             FRAME_SYNC,
    output logic             FRAME_DONE,
    output logic             FRAME_ABORT,
    output logic [7:0]       FRAME_CNT
);

`ifdef FRAME_HEADER_EN
    localparam state_t FIRST = HDR0;
`else
    localparam state_t FIRST = FETCH;
`endif

    state_t           state, state_n;
    logic [LEN_W-1:0] remaining;
    logic             hs, last, start, drop, starve, expire, timeout;

    assign hs      = OUT_VALID & OUT_READY;
    assign last    = (remaining == LEN_W'(1));
    assign start   = ENABLE & FIFO_READY & (FRAME_LENGTH != '0);
    // DONE is excluded: the frame has already completed its last handshake
    assign drop    = ~ENABLE & (state != IDLE) & (state != DONE);
    assign starve  = (state == FETCH) & ENABLE & ~FIFO_READY;
    assign timeout = starve & expire;

    starvation_timer #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (state != FETCH),
        .en    (starve),
        .expire(expire)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        FIFO_RD = 1'b0;
        case (state)
            IDLE:      if (start) state_n = FIRST;
`ifdef FRAME_HEADER_EN
            HDR0:      if (hs) state_n = HDR1;
            HDR1:      if (hs) state_n = FETCH;
`endif
            FETCH: begin
                FIFO_RD = ENABLE & FIFO_READY;
                if (FIFO_READY)
                    state_n = WAIT_DATA;
                else if (expire)
                    state_n = IDLE;
            end
            WAIT_DATA: state_n = PRESENT;
            PRESENT:   if (hs) state_n = last ? DONE : FETCH;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (drop)
            state_n = IDLE;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            remaining   <= '0;
            OUT_DATA    <= '0;
            OUT_VALID   <= 1'b0;
            FRAME_SYNC  <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_ABORT <= 1'b0;
            FRAME_CNT   <= '0;
        end else begin
            FRAME_DONE  <= (state == PRESENT) & hs & last & ENABLE;
            FRAME_ABORT <= drop | timeout;
            if (state == DONE)
                FRAME_CNT <= FRAME_CNT + 8'd1;
            if (state == IDLE && start)
                remaining <= FRAME_LENGTH;
            else if (state == PRESENT && hs && ENABLE)
                remaining <= remaining - LEN_W'(1);
            if (drop || timeout) begin
                OUT_VALID  <= 1'b0;
                FRAME_SYNC <= 1'b0;
            end else begin
                case (state)
`ifdef FRAME_HEADER_EN
                    IDLE: if (start) begin
                        OUT_DATA   <= HDR_SYNC;
                        OUT_VALID  <= 1'b1;
                        FRAME_SYNC <= 1'b1;
                    end
                    HDR0: if (hs) OUT_DATA <= FRAME_CNT;
                    HDR1: if (hs) OUT_VALID <= 1'b0;
`endif
                    WAIT_DATA: begin
                        OUT_DATA   <= FIFO_DATA;
                        OUT_VALID  <= 1'b1;
                        FRAME_SYNC <= 1'b1;
                    end
                    PRESENT: if (hs) begin
                        OUT_VALID <= 1'b0;
                        if (last)
                            FRAME_SYNC <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_readout_scheduler.sv
// tb_frame_readout_scheduler: directed vector table plus hand-written frame sequences for frame_readout_scheduler
module tb_frame_readout_scheduler;

    logic        CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0, FIFO_READY = 1'b0, OUT_READY = 1'b0;
    logic [15:0] FRAME_LENGTH = '0;
    logic [7:0]  FIFO_DATA = '0;
    logic        FIFO_RD, OUT_VALID, FRAME_SYNC, FRAME_DONE, FRAME_ABORT;
    logic [7:0]  OUT_DATA, FRAME_CNT;

    int          n_vec = 0, n_err = 0, rd_ptr = 0, exp_ptr = 0, stab_err = 0;
    logic [7:0]  exp_cnt = '0;
    logic        pend = 1'b0;
    logic [7:0]  pdat = '0;

    typedef struct packed {
        logic [2:0]  ins;
        logic [15:0] len;
        logic [4:0]  flg;
        logic [7:0]  dat;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [16];

    frame_readout_scheduler #(
        .TIMEOUT_CYCLES(8),
        .LEN_W         (16)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .FRAME_LENGTH(FRAME_LENGTH),
        .FIFO_READY  (FIFO_READY),
        .FIFO_DATA   (FIFO_DATA),
        .FIFO_RD     (FIFO_RD),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .FRAME_SYNC  (FRAME_SYNC),
        .FRAME_DONE  (FRAME_DONE),
        .FRAME_ABORT (FRAME_ABORT),
        .FRAME_CNT   (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] fdat(input int p);
        return 8'((p + 1) * 17);
    endfunction

    always @(posedge CLK) begin
        if (FIFO_RD) begin
            FIFO_DATA <= fdat(rd_ptr);
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge CLK) begin
        #3;
        if (pend && OUT_VALID && OUT_DATA != pdat)
            stab_err++;
        pend = OUT_VALID && !OUT_READY;
        pdat = OUT_DATA;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!OUT_VALID && n < 20) begin
            cyc();
            n++;
        end
        chk({nm, ".valid"}, 16'(OUT_VALID), 16'd1);
    endtask

    task automatic take(input logic [7:0] exp, input int hold, input string nm);
        int r0;
        wait_valid(nm);
        r0 = rd_ptr;
        for (int i = 0; i < hold; i++) begin
            chk({nm, ".held"}, 16'({OUT_VALID, OUT_DATA}), 16'({1'b1, exp}));
            cyc();
        end
        OUT_READY = 1'b1;
        #1;
        chk({nm, ".data"}, 16'(OUT_DATA), 16'(exp));
        chk({nm, ".rd"}, 16'(rd_ptr), 16'(r0));
        cyc();
        OUT_READY = 1'b0;
    endtask

    task automatic hdr(input string nm);
`ifdef FRAME_HEADER_EN
        take(8'hA5, 0, {nm, ".h0"});
        take(exp_cnt, 0, {nm, ".h1"});
`else
        if (nm.len() == 0)
            $display("empty frame name");
`endif
    endtask

    task automatic run_frame(input int len, input int hold_at, input int hold, input string nm);
        ENABLE       = 1'b1;
        FIFO_READY   = 1'b1;
        OUT_READY    = 1'b0;
        FRAME_LENGTH = 16'(len);
        hdr(nm);
        for (int b = 0; b < len; b++) begin
            take(fdat(exp_ptr), (b == hold_at) ? hold : 0, nm);
            exp_ptr++;
        end
        chk({nm, ".done"}, 16'(FRAME_DONE), 16'd1);
        chk({nm, ".reads"}, 16'(rd_ptr), 16'(exp_ptr));
        exp_cnt++;
    endtask

    initial begin
        //           {en,frdy,ordy} len    {rd,vld,sync,done,abort} data   cnt
        tbl[0]  = '{3'b111, 16'd4, 5'b00000, 8'h00, 8'd0};
        tbl[1]  = '{3'b111, 16'd4, 5'b10000, 8'h00, 8'd0};
        tbl[2]  = '{3'b111, 16'd4, 5'b00000, 8'h00, 8'd0};
        tbl[3]  = '{3'b111, 16'd4, 5'b01100, 8'h11, 8'd0};
        tbl[4]  = '{3'b111, 16'd4, 5'b10100, 8'h11, 8'd0};
        tbl[5]  = '{3'b111, 16'd4, 5'b00100, 8'h11, 8'd0};
        tbl[6]  = '{3'b111, 16'd4, 5'b01100, 8'h22, 8'd0};
        tbl[7]  = '{3'b111, 16'd4, 5'b10100, 8'h22, 8'd0};
        tbl[8]  = '{3'b111, 16'd4, 5'b00100, 8'h22, 8'd0};
        tbl[9]  = '{3'b111, 16'd4, 5'b01100, 8'h33, 8'd0};
        tbl[10] = '{3'b111, 16'd4, 5'b10100, 8'h33, 8'd0};
        tbl[11] = '{3'b111, 16'd4, 5'b00100, 8'h33, 8'd0};
        tbl[12] = '{3'b111, 16'd4, 5'b01100, 8'h44, 8'd0};
        tbl[13] = '{3'b111, 16'd4, 5'b00010, 8'h44, 8'd0};
        tbl[14] = '{3'b111, 16'd0, 5'b00000, 8'h44, 8'd1};
        tbl[15] = '{3'b111, 16'd0, 5'b00000, 8'h44, 8'd1};

        repeat (2) cyc();
        chk("reset.flags", 16'({FIFO_RD, OUT_VALID, FRAME_SYNC, FRAME_DONE, FRAME_ABORT}), 16'd0);
        chk("reset.data", 16'(OUT_DATA), 16'd0);
        chk("reset.cnt", 16'(FRAME_CNT), 16'd0);
        RESET = 1'b0;
        cyc();

`ifndef FRAME_HEADER_EN
        for (int i = 0; i < 16; i++) begin
            cyc();
            {ENABLE, FIFO_READY, OUT_READY} = tbl[i].ins;
            FRAME_LENGTH = tbl[i].len;
            #1;
            chk($sformatf("nom%0d.flags", i), 16'({FIFO_RD, OUT_VALID, FRAME_SYNC, FRAME_DONE, FRAME_ABORT}), 16'(tbl[i].flg));
            chk($sformatf("nom%0d.data", i), 16'(OUT_DATA), 16'(tbl[i].dat));
            chk($sformatf("nom%0d.cnt", i), 16'(FRAME_CNT), 16'(tbl[i].cnt));
        end
        OUT_READY = 1'b0;
        exp_ptr   = 4;
        exp_cnt   = 8'd1;
`endif

        cyc();
        run_frame(4, 1, 5, "bp");
        FRAME_LENGTH = 0;
        cyc();
        chk("bp.cnt", 16'(FRAME_CNT), 16'(exp_cnt));

        FRAME_LENGTH = 4;
        hdr("starve");
        wait_valid("starve.b1");
        chk("starve.b1.data", 16'(OUT_DATA), 16'(fdat(exp_ptr)));
        exp_ptr++;
        FIFO_READY = 1'b0;
        OUT_READY  = 1'b1;
        cyc();
        OUT_READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("starve.c%0d", i), 16'({FIFO_RD, FRAME_ABORT}), 16'd0);
            cyc();
        end
        chk("starve.abort", 16'({FRAME_ABORT, OUT_VALID, FRAME_SYNC, FRAME_DONE}), 16'b1000);
        chk("starve.cnt", 16'(FRAME_CNT), 16'(exp_cnt));
        FRAME_LENGTH = 0;
        FIFO_READY   = 1'b1;
        cyc();
        chk("starve.pulse", 16'(FRAME_ABORT), 16'd0);
        repeat (3) cyc();
        chk("starve.reads", 16'(rd_ptr), 16'(exp_ptr));

        FRAME_LENGTH = 4;
        hdr("drop");
        for (int b = 0; b < 2; b++) begin
            take(fdat(exp_ptr), 0, "drop.b");
            exp_ptr++;
        end
        wait_valid("drop.b3");
        chk("drop.b3.data", 16'(OUT_DATA), 16'(fdat(exp_ptr)));
        exp_ptr++;
        ENABLE       = 1'b0;
        FRAME_LENGTH = 0;
        cyc();
        chk("drop.abort", 16'({FRAME_ABORT, OUT_VALID, FRAME_SYNC, FRAME_DONE}), 16'b1000);
        cyc();
        chk("drop.after", 16'({FRAME_ABORT, FRAME_DONE, FRAME_CNT}), 16'({2'b00, exp_cnt}));
        chk("drop.reads", 16'(rd_ptr), 16'(exp_ptr));

        ENABLE       = 1'b1;
        FRAME_LENGTH = 1;
        hdr("sim");
        wait_valid("sim.b");
        exp_ptr++;
        ENABLE       = 1'b0;
        OUT_READY    = 1'b1;
        FRAME_LENGTH = 0;
        cyc();
        OUT_READY = 1'b0;
        chk("sim.abort", 16'({FRAME_ABORT, FRAME_DONE, OUT_VALID}), 16'b100);
        cyc();
        chk("sim.cnt", 16'(FRAME_CNT), 16'(exp_cnt));

        for (int f = 0; f < 256; f++) begin
            run_frame(1, -1, 0, $sformatf("wrap%0d", f));
            cyc();
            chk($sformatf("wrap%0d.cnt", f), 16'(FRAME_CNT), 16'(exp_cnt));
        end
        FRAME_LENGTH = 0;
        cyc();

        FRAME_LENGTH = 4;
        wait_valid("rst");
        RESET = 1'b1;
        #1;
        chk("rst.flags", 16'({FIFO_RD, OUT_VALID, FRAME_SYNC, FRAME_DONE, FRAME_ABORT}), 16'd0);
        chk("rst.data", 16'(OUT_DATA), 16'd0);
        chk("rst.cnt", 16'(FRAME_CNT), 16'd0);
        cyc();
        FRAME_LENGTH = 0;
        RESET        = 1'b0;
        begin
            int r0;
            r0 = rd_ptr;
            repeat (10) cyc();
            chk("zero.reads", 16'(rd_ptr), 16'(r0));
            chk("zero.valid", 16'(OUT_VALID), 16'd0);
        end

        chk("stable", 16'(stab_err), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_readout_scheduler.md
# frame_readout_scheduler

Sequences readout of the sample store into the parallel data-out port, one frame at a time. It sits between the `Storeage` FIFO (its `READ`, `DOUT` and `READY2READ` signals) and `parallelInterface`, and replaces the free-running read strobe.
- For each frame it waits for the store to be ready, issues exactly `FRAME_LENGTH` read strobes and presents each byte with a valid/ready handshake.
- It frames the burst with a sync flag and reports completion or abort.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum number of consecutive cycles spent in `FETCH` with `FIFO_READY` low while inside a frame; exceeding it aborts the frame.
- `LEN_W`, default 16: width of the frame-length field and the internal byte counter.

Ports:
- `CLK`, in, 1: system clock (64 MHz). Single clock domain.
- `RESET`, in, 1: asynchronous, active-high reset.
- `ENABLE`, in, 1: run enable. Low forces `IDLE`.
- `FRAME_LENGTH`, in, `LEN_W`: payload bytes per frame. Sampled on frame start.
- `FIFO_READY`, in, 1: store holds data (`READY2READ`).
- `FIFO_DATA`, in, 8: store read data, valid 1 cycle after `FIFO_RD`.
- `FIFO_RD`, out, 1: 1-cycle read strobe.
- `OUT_DATA`, out, 8: byte to the parallel port.
- `OUT_VALID`, out, 1: `OUT_DATA` is valid.
- `OUT_READY`, in, 1: parallel port accepts the byte.
- `FRAME_SYNC`, out, 1: high from the first presented byte until the last handshake.
- `FRAME_DONE`, out, 1: 1-cycle pulse after a complete frame.
- `FRAME_ABORT`, out, 1: 1-cycle pulse on timeout or `ENABLE` drop mid-frame.
- `FRAME_CNT`, out, 8: completed-frame counter, wraps 255→0.

## Operation
States: `IDLE`, `HDR0`, `HDR1`, `FETCH`, `WAIT_DATA`, `PRESENT`, `DONE`.
- **IDLE**
  - Start condition: `ENABLE`=1, `FIFO_READY`=1 and `FRAME_LENGTH`≠0.
  - On start, latch `FRAME_LENGTH` into `remaining` and go to `HDR0` (header build) or `FETCH` (no header).
  - `FRAME_LENGTH`=0 never starts a frame.
- **FETCH**
  - If `FIFO_READY`=1: pulse `FIFO_RD` and go to `WAIT_DATA`.
  - Otherwise increment the starvation counter. Reaching `TIMEOUT_CYCLES` pulses `FRAME_ABORT` and returns to `IDLE`.
  - The starvation counter clears on every `FIFO_RD`.
- **WAIT_DATA**: register `FIFO_DATA` into `OUT_DATA`, set `OUT_VALID`, go to `PRESENT`.
- **PRESENT**
  - Hold `OUT_DATA` and `OUT_VALID` stable until `OUT_VALID`&`OUT_READY`.
  - On that handshake: decrement `remaining`; if it was 1 go to `DONE`, else clear `OUT_VALID` and go to `FETCH`.
- **DONE**: pulse `FRAME_DONE`, increment `FRAME_CNT`, clear `FRAME_SYNC`, return to `IDLE`.
- **ENABLE drop**: `ENABLE`=0 in any non-`IDLE` state goes to `IDLE` on the next edge. It clears `OUT_VALID` and `FRAME_SYNC`, pulses `FRAME_ABORT`, and does not increment `FRAME_CNT`.
- **Abort and the store**: an abort never issues further `FIFO_RD`. Unread bytes remain in the store.
- **Counter width**: `remaining` is `LEN_W` bits and never underflows; the decrement is gated by the state.

## Timing
- **Reset values**: all outputs 0, state `IDLE`, `FRAME_CNT`=0, `remaining`=0.
- **Read latency**: `FIFO_RD` at cycle t gives `OUT_VALID` rising at t+2.
- **Throughput**: minimum 3 cycles per byte with `OUT_READY` tied high.
- **Handshake**: `OUT_DATA` changes only in `WAIT_DATA` or header states, never while `OUT_VALID`=1 and `OUT_READY`=0.
- **End of frame**: `FRAME_DONE` occurs 1 cycle after the last handshake. The next frame may start in the cycle after `DONE`.
- **Simultaneous events**: `ENABLE` falling in the same cycle as the last handshake counts as an abort; `ENABLE` has priority.

## Configuration
- **`FRAME_HEADER_EN` defined**: `HDR0` presents 0xA5 and `HDR1` presents `FRAME_CNT`, each with the same valid/ready handshake. Headers do not count toward `FRAME_LENGTH`. `FRAME_SYNC` rises with `HDR0`.
- **`FRAME_HEADER_EN` undefined**: the header states are not built. `IDLE` goes directly to `FETCH`. Frames carry payload bytes only.

## Structure
- **Shared package / defines**: state encoding localparams, the header sync constant 0xA5, and the default `TIMEOUT_CYCLES`, alongside the existing `Defines.v` constants.
- **Sub-module**: one sub-module, `starvation_timer` (loadable down-counter with clear and expire pulse). Everything else stays flat.

## Test plan
- **Nominal frame**: `FRAME_LENGTH`=4, `FIFO_READY`=1, FIFO returns 0x11,0x22,0x33,0x44, `OUT_READY`=1 → 4 `FIFO_RD` pulses 3 cycles apart, bytes in order, one `FRAME_DONE` pulse, `FRAME_CNT`=1.
- **Back-pressure**: `OUT_READY` low for 5 cycles on byte 2 → `OUT_DATA` held at 0x22, no extra `FIFO_RD`, frame completes with 4 bytes.
- **Starvation timeout**: `TIMEOUT_CYCLES`=8; `FIFO_READY` drops after byte 1 of a 4-byte frame → `FRAME_ABORT` after 8 starved cycles, `FRAME_CNT` unchanged, `IDLE`.
- **Enable drop**: `ENABLE` low during `PRESENT` of byte 3 → `OUT_VALID`=0 next cycle, `FRAME_ABORT` pulse, no `FRAME_DONE`.
- **Header and wrap**: with `FRAME_HEADER_EN`, run 256 frames of length 1 → each frame presents 0xA5, then the count, then the payload; `FRAME_CNT` wraps to 0.
- **Reset mid-frame and zero length**: assert `RESET` mid-frame → all outputs 0 immediately. `FRAME_LENGTH`=0 → no `FIFO_RD` is ever issued.
